// File: rtl/alu_pkg.sv
// Shared constants and payload type for the execute-stage issue unit.
package alu_pkg;

    localparam int PKG_XLEN = 64;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ALU_Op = {Ainv, Binv, Op[1:0]}
    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_SUB = 4'b0110;
    localparam logic [3:0] ALUOP_SLT = 4'b0111;
    localparam logic [3:0] ALUOP_NOR = 4'b1100;

    typedef struct packed {
        logic [PKG_XLEN-1:0] result;
        logic [4:0]          rd;
        logic                zero;
        logic                overflow;
        logic                carry;
        logic                taken;
        logic                illegal;
    } ex_payload_t;

endpackage

// File: rtl/ALU_64bit.sv
// Combinational ALU: optional A/B inversion feeding AND/OR/adder/set-less-than.
module ALU_64bit #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      ALU_Op,
    output logic [XLEN-1:0] R,
    output logic            zero,
    output logic            Overflow,
    output logic            CarryOut
);

    logic [XLEN-1:0] aa;
    logic [XLEN-1:0] bb;
    logic [XLEN-1:0] sum;
    logic            cout;

    always_comb begin
        aa = ALU_Op[3] ? ~a : a;
        bb = ALU_Op[2] ? ~b : b;
        // Binv doubles as carry-in so that SUB becomes a + ~b + 1
        {cout, sum} = {1'b0, aa} + {1'b0, bb} + {{XLEN{1'b0}}, ALU_Op[2]};
        Overflow = (aa[XLEN-1] == bb[XLEN-1]) && (sum[XLEN-1] != aa[XLEN-1]);
        CarryOut = cout;
        case (ALU_Op[1:0])
            2'b00:   R = aa & bb;
            2'b01:   R = aa | bb;
            2'b10:   R = sum;
            default: R = {{(XLEN-1){1'b0}}, sum[XLEN-1] ^ Overflow};
        endcase
        zero = (R == '0);
    end

endmodule

// File: rtl/alu_ctrl_dec.sv
// Decodes opcode/funct3/funct7[5] into ALU_Op, B-operand select and branch/illegal flags.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_op,
    output logic       b_sel_imm,
    output logic       is_branch,
    output logic       illegal
);

    always_comb begin
        alu_op    = ALUOP_AND;
        b_sel_imm = 1'b0;
        is_branch = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_OP: begin
                case (funct3)
                    3'b000:  alu_op = funct7_5 ? ALUOP_SUB : ALUOP_ADD;
                    3'b111:  alu_op = ALUOP_AND;
                    3'b110:  alu_op = ALUOP_OR;
                    3'b010:  alu_op = ALUOP_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                b_sel_imm = 1'b1;
                case (funct3)
                    3'b000:  alu_op = ALUOP_ADD;
                    3'b111:  alu_op = ALUOP_AND;
                    3'b110:  alu_op = ALUOP_OR;
                    3'b010:  alu_op = ALUOP_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                alu_op    = ALUOP_ADD;
                b_sel_imm = 1'b1;
            end
            OPC_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    alu_op    = ALUOP_SUB;
                    is_branch = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ex_stage.sv
// Execute-stage issue unit: decode, ALU, and a main+skid output register with valid/ready.
module alu_ex_stage
    import alu_pkg::*;
#(
    parameter int XLEN = PKG_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_zero,
    output logic            out_overflow,
    output logic            out_carry,
    output logic            out_taken,
    output logic            out_illegal
);

    logic [3:0]      alu_op;
    logic            b_sel_imm;
    logic            is_branch;
    logic            illegal;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_r;
    logic            alu_zero;
    logic            alu_ov;
    logic            alu_carry;

    ex_payload_t     new_pl;
    ex_payload_t     m_q, m_d;
    ex_payload_t     s_q, s_d;
    logic            m_valid_q, m_valid_d;
    logic            s_valid_q, s_valid_d;
    logic            accept;
    logic            m_free;

    alu_ctrl_dec u_dec (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .alu_op    (alu_op),
        .b_sel_imm (b_sel_imm),
        .is_branch (is_branch),
        .illegal   (illegal)
    );

    assign alu_b = b_sel_imm ? imm : rs2_val;

    ALU_64bit #(.XLEN(XLEN)) u_alu (
        .a        (rs1_val),
        .b        (alu_b),
        .ALU_Op   (alu_op),
        .R        (alu_r),
        .zero     (alu_zero),
        .Overflow (alu_ov),
        .CarryOut (alu_carry)
    );

    always_comb begin
        new_pl         = '0;
        new_pl.rd      = rd;
        new_pl.illegal = illegal;
        if (!illegal) begin
            new_pl.result   = alu_r;
            new_pl.zero     = alu_zero;
            new_pl.overflow = alu_ov;
            new_pl.carry    = alu_carry;
            new_pl.taken    = is_branch && (funct3[0] ? !alu_zero : alu_zero);
        end
    end

    // in_ready comes straight from a flop, so upstream never sees a combinational path
    assign in_ready = !s_valid_q;
    assign accept   = in_valid && in_ready;
    assign m_free   = !m_valid_q || out_ready;

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (m_free) begin
            if (s_valid_q) begin
                m_d       = s_q;
                m_valid_d = 1'b1;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_d       = new_pl;
                m_valid_d = 1'b1;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            s_d       = new_pl;
            s_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

    assign out_valid    = m_valid_q;
    assign out_result   = m_q.result;
    assign out_rd       = m_q.rd;
    assign out_zero     = m_q.zero;
    assign out_overflow = m_q.overflow;
    assign out_carry    = m_q.carry;
    assign out_taken    = m_q.taken;
    assign out_illegal  = m_q.illegal;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: directed cases plus a scoreboarded random stream.
module tb_alu_ex_stage;
    import alu_pkg::*;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [63:0] rs1_val, rs2_val, imm;
    logic [4:0]  rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_zero, out_overflow, out_carry, out_taken, out_illegal;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_out    = 0;
    ex_payload_t sb[$];

    always #5 clk = ~clk;

    alu_ex_stage #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_zero(out_zero),
        .out_overflow(out_overflow), .out_carry(out_carry),
        .out_taken(out_taken), .out_illegal(out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic ex_payload_t model(input logic [6:0] op, input logic [2:0] f3,
                                          input logic f7, input logic [63:0] a,
                                          input logic [63:0] b, input logic [63:0] im,
                                          input logic [4:0] r);
        ex_payload_t p;
        int          kind;   // 0 and, 1 or, 2 add, 3 sub, 4 slt, -1 illegal
        logic        usei, br, ov;
        logic [63:0] bv, res;
        logic [64:0] s;
        kind = -1; usei = 1'b0; br = 1'b0;
        if (op == OP || op == OPI) begin
            usei = (op == OPI);
            case (f3)
                3'd0: kind = (op == OP && f7) ? 3 : 2;
                3'd7: kind = 0;
                3'd6: kind = 1;
                3'd2: kind = 4;
                default: kind = -1;
            endcase
        end else if (op == LD || op == ST) begin
            kind = 2; usei = 1'b1;
        end else if (op == BR && f3 <= 3'd1) begin
            kind = 3; br = 1'b1;
        end
        bv = usei ? im : b;
        p = '0;
        p.rd = r;
        if (kind < 0) begin
            p.illegal = 1'b1;
            return p;
        end
        if (kind >= 3) begin
            s  = {1'b0, a} + {1'b0, ~bv} + 65'd1;
            ov = (a[63] != bv[63]) && (s[63] != a[63]);
        end else begin
            s  = {1'b0, a} + {1'b0, bv};
            ov = (a[63] == bv[63]) && (s[63] != a[63]);
        end
        case (kind)
            0:       res = a & bv;
            1:       res = a | bv;
            4:       res = ($signed(a) < $signed(bv)) ? 64'd1 : 64'd0;
            default: res = s[63:0];
        endcase
        p.result   = res;
        p.zero     = (res == 64'd0);
        p.overflow = ov;
        p.carry    = s[64];
        p.taken    = br && (f3[0] ? (res != 64'd0) : (res == 64'd0));
        return p;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_output", {63'd0, out_valid}, 64'd0);
                end else begin
                    ex_payload_t e;
                    e = sb.pop_front();
                    chk("sb_result", out_result, e.result);
                    chk("sb_fields",
                        {54'd0, out_rd, out_zero, out_overflow, out_carry, out_taken, out_illegal},
                        {54'd0, e.rd, e.zero, e.overflow, e.carry, e.taken, e.illegal});
                end
            end
            if (in_valid && in_ready && !flush)
                sb.push_back(model(opcode, funct3, funct7_5, rs1_val, rs2_val, imm, rd));
        end
    end

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                         input logic [4:0] r);
        opcode = op; funct3 = f3; funct7_5 = f7;
        rs1_val = a; rs2_val = b; imm = im; rd = r;
        in_valid = 1'b1;
    endtask

    // Entered and left at posedge+1; assumes an empty pipeline with out_ready high.
    task automatic issue_one(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                             input logic [4:0] r);
        drive(op, f3, f7, a, b, im, r);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("latency_valid", {63'd0, out_valid}, 64'd1);
    endtask

    // Holds an instruction on the input until accepted or the budget runs out.
    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                        input logic [4:0] r, input bit rand_ready);
        bit acc;
        acc = 1'b0;
        drive(op, f3, f7, a, b, im, r);
        for (int c = 0; c < 40 && !acc; c++) begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (sb.size() != 0 || out_valid); c++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", sb.size(), 64'd0);
    endtask

    initial begin
        int acc_cnt, idx, n0;
        bit acc;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; funct3 = '0; funct7_5 = 1'b0;
        rs1_val = '0; rs2_val = '0; imm = '0; rd = '0;

        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_result", out_result, 64'd0);
        chk("rst_fields", {54'd0, out_rd, out_zero, out_overflow, out_carry, out_taken, out_illegal}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        issue_one(OP, 3'd0, 1'b0, 64'd20, 64'd120, 64'd0, 5'd1);
        chk("add_result", out_result, 64'd140);
        chk("add_zero_ov", {62'd0, out_zero, out_overflow}, 64'd0);
        issue_one(OP, 3'd0, 1'b1, 64'd20, 64'd120, 64'd0, 5'd2);
        chk("sub_result", out_result, -64'd100);
        issue_one(OP, 3'd2, 1'b0, 64'd20, 64'd120, 64'd0, 5'd3);
        chk("slt_true", out_result, 64'd1);
        issue_one(OP, 3'd2, 1'b0, 64'd120, 64'd20, 64'd0, 5'd4);
        chk("slt_false", out_result, 64'd0);
        issue_one(OP, 3'd0, 1'b0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd0, 5'd5);
        chk("ovf_result", out_result, 64'h8000_0000_0000_0000);
        chk("ovf_flags", {62'd0, out_overflow, out_carry}, 64'd2);
        issue_one(BR, 3'd0, 1'b0, 64'd20, 64'd20, 64'd0, 5'd0);
        chk("beq_zero_taken", {62'd0, out_zero, out_taken}, 64'd3);
        issue_one(BR, 3'd1, 1'b0, 64'd20, 64'd20, 64'd0, 5'd0);
        chk("bne_taken", {63'd0, out_taken}, 64'd0);
        issue_one(BR, 3'd2, 1'b0, 64'd20, 64'd20, 64'd0, 5'd0);
        chk("br_illegal", {63'd0, out_illegal}, 64'd1);
        chk("br_illegal_result", out_result, 64'd0);
        issue_one(OPI, 3'd0, 1'b1, 64'd20, 64'd999, 64'd5, 5'd6);
        chk("addi_f7_ignored", out_result, 64'd25);
        issue_one(LD, 3'd3, 1'b0, 64'd100, 64'd7, -64'd8, 5'd7);
        chk("load_addr", out_result, 64'd92);
        issue_one(7'b1111111, 3'd0, 1'b0, 64'd5, 64'd5, 64'd0, 5'd8);
        chk("bad_opc_illegal", {54'd0, out_rd, out_zero, out_overflow, out_carry, out_taken, out_illegal},
            {54'd0, 5'd8, 5'b00001});
        drain();

        // Backpressure: three ADDs against a stalled output
        out_ready = 1'b0;
        n0 = n_out; idx = 0; acc_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 3) drive(OP, 3'd0, 1'b0, 64'(idx + 1), 64'(idx + 1), 64'd0, 5'(10 + idx));
            acc = in_ready && (idx < 3);
            @(posedge clk); #1;
            if (acc) begin
                idx++; acc_cnt++;
                if (acc_cnt == 2) chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            end
        end
        chk("bp_accepted", acc_cnt, 64'd2);
        chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_hold_result", out_result, 64'd2);
        out_ready = 1'b1;
        for (int c = 0; c < 10 && idx < 3; c++) begin
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        drain();
        chk("bp_outputs", n_out - n0, 64'd3);

        // Flush with M and S full and a same-cycle input
        out_ready = 1'b0;
        send(OP, 3'd0, 1'b0, 64'd1, 64'd1, 64'd0, 5'd20, 1'b0);
        send(OP, 3'd0, 1'b0, 64'd2, 64'd2, 64'd0, 5'd21, 1'b0);
        chk("fl_s_full", {63'd0, in_ready}, 64'd0);
        drive(OP, 3'd0, 1'b0, 64'd7, 64'd7, 64'd0, 5'd31);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("fl_no_ghost", {63'd0, out_valid}, 64'd0);
        end
        // Flush while an accept would otherwise land in an empty M
        drive(OP, 3'd0, 1'b0, 64'd9, 64'd9, 64'd0, 5'd30);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_drop_accept", {63'd0, out_valid}, 64'd0);

        // Scoreboarded random stream with random backpressure
        for (int k = 0; k < 40; k++) begin
            logic [6:0] op;
            logic [63:0] a, b;
            case ($urandom_range(0, 5))
                0: op = OP; 1: op = OPI; 2: op = LD; 3: op = ST; 4: op = BR;
                default: op = 7'b1110111;
            endcase
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 2) == 0) ? a : {$urandom, $urandom};
            send(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 a, b, {$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'b1);
        end
        drain();

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(OP, 3'd0, 1'b0, 64'd3, 64'd4, 64'd0, 5'd12, 1'b0);
        send(OP, 3'd0, 1'b0, 64'd5, 64'd4, 64'd0, 5'd13, 1'b0);
        drive(OP, 3'd0, 1'b0, 64'd1, 64'd1, 64'd0, 5'd14);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_result", out_result, 64'd0);
        chk("arst_fields", {54'd0, out_rd, out_zero, out_overflow, out_carry, out_taken, out_illegal}, 64'd0);
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("arst_no_output", {63'd0, out_valid}, 64'd0);
        issue_one(OP, 3'd0, 1'b0, 64'd5, 64'd6, 64'd0, 5'd3);
        chk("arst_first_result", out_result, 64'd11);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
